// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix-op engines.
// Contents: slot metadata layout constant, operation status codes,
//           convolution-generator FSM states and the output matrix name.
package matrix_op_defs_pkg;

  // Each matrix slot starts with this many metadata words before its data.
  localparam int MATRIX_METADATA_WORDS = 1;

  typedef enum logic [2:0] {
    MATRIX_OP_STATUS_SUCCESS = 3'd0,
    MATRIX_OP_STATUS_IDLE    = 3'd1,
    MATRIX_OP_STATUS_BUSY    = 3'd2,
    MATRIX_OP_STATUS_ERR_DIM = 3'd3
  } matrix_op_status_e;

  typedef enum logic [3:0] {
    CONV_IDLE,
    CONV_RD_META_K,
    CONV_RD_META_I,
    CONV_CHECK,
    CONV_LOAD_K,
    CONV_REQ_WR,
    CONV_COMPUTE,
    CONV_EMIT,
    CONV_WAIT_DONE,
    CONV_DONE,
    CONV_ERROR
  } conv_state_e;

  // "CONV" followed by four NUL bytes, first character in the top byte.
  localparam logic [63:0] CONV_MATRIX_NAME = 64'h434F_4E56_0000_0000;

endpackage

// File: rtl/matrix_op_conv_gen_if.sv
// Bus bundle between the convolution generator, its BRAM read port and
// the result-matrix writer.
// master: the generator (drives read_addr and the writer-facing outputs).
// slave : the memory/writer side.
interface matrix_op_conv_gen_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  write_request;
  logic                  write_ready;
  logic [2:0]            matrix_id;
  logic [7:0]            actual_rows;
  logic [7:0]            actual_cols;
  logic [7:0][7:0]       matrix_name;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  writer_ready;
  logic                  write_done;

  modport master (
    output read_addr, write_request, matrix_id, actual_rows, actual_cols,
           matrix_name, data_in, data_valid,
    input  data_out, write_ready, writer_ready, write_done
  );

  modport slave (
    input  read_addr, write_request, matrix_id, actual_rows, actual_cols,
           matrix_name, data_in, data_valid,
    output data_out, write_ready, writer_ready, write_done
  );
endinterface

// File: rtl/conv_mac_unit.sv
// Multiply-accumulate for one convolution output element.
// Ports: clk/rst, clear (zero the accumulator, wins over enable),
//        enable (add a*b), a/b operands, acc wrapped accumulator.
module conv_mac_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] acc
);

  // The low DATA_WIDTH bits of a two's complement product do not depend on
  // signedness, so an unsigned multiply truncated to DATA_WIDTH is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc + a * b;
  end

endmodule

// File: rtl/matrix_op_conv_gen.sv
// 2-D cross-correlation of an image slot with a kernel slot, result
// streamed to the matrix writer.
// Ports: clk, rst (async, active-high); start + kernel/image/dst slot ids
//        and stride2 as the command; busy/status report progress; bus
//        carries the BRAM read port and the writer handshake.
module matrix_op_conv_gen
  import matrix_op_defs_pkg::*;
#(
  parameter int BLOCK_SIZE = 1024,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_K      = 5,
  parameter int MAX_DIM    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          kernel_src_id,
  input  logic [2:0]          image_src_id,
  input  logic [2:0]          dst_id,
  input  logic                stride2,
  output logic                busy,
  output matrix_op_status_e   status,
  matrix_op_conv_gen_if.master bus
);

  // Counter width covers 0..MAX_K*MAX_K; the cache is sized to match exactly.
  localparam int CW     = $clog2(MAX_K * MAX_K + 1);
  localparam int KDEPTH = 1 << CW;
  localparam logic [7:0] MAX_K8   = 8'(MAX_K);
  localparam logic [7:0] MAX_DIM8 = 8'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] META = ADDR_WIDTH'(MATRIX_METADATA_WORDS);

  conv_state_e           state;
  logic [2:0]            k_id, i_id, d_id;
  logic                  s2, meta_phase;
  logic [7:0]            kr, kc, ir, ic, or_n, oc_n;
  logic [7:0]            out_r, out_c, tkr, tkc;
  logic [CW-1:0]         nk, iss_cnt, cap_cnt, tap_p0, tap_p1;
  logic                  rd_v0, rd_v1;
  logic [DATA_WIDTH-1:0] kcache [KDEPTH];
  logic                  mac_clear, mac_en;
  logic [DATA_WIDTH-1:0] mac_acc;
  logic [ADDR_WIDTH-1:0] k_base, i_base, row_a, col_a, img_addr;
  logic                  dim_bad;

  always_comb begin
    k_base   = ADDR_WIDTH'(k_id) * ADDR_WIDTH'(BLOCK_SIZE);
    i_base   = ADDR_WIDTH'(i_id) * ADDR_WIDTH'(BLOCK_SIZE);
    row_a    = (ADDR_WIDTH'(out_r) << s2) + ADDR_WIDTH'(tkr);
    col_a    = (ADDR_WIDTH'(out_c) << s2) + ADDR_WIDTH'(tkc);
    img_addr = i_base + META + row_a * ADDR_WIDTH'(ic) + col_a;
    dim_bad  = (kr == 8'd0) || (kc == 8'd0) || (kr > MAX_K8) || (kc > MAX_K8) ||
               (ir > MAX_DIM8) || (ic > MAX_DIM8) || (kr > ir) || (kc > ic);
    // rd_v1 marks the cycle in which data_out answers the read issued two
    // edges earlier; tap_p1 is the kernel index that read belongs to.
    mac_en    = (state == CONV_COMPUTE) && rd_v1;
    mac_clear = ((state == CONV_REQ_WR) && bus.write_ready) ||
                ((state == CONV_EMIT) && bus.writer_ready);
  end

  conv_mac_unit #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .enable (mac_en),
    .a      (kcache[tap_p1]),
    .b      (bus.data_out),
    .acc    (mac_acc)
  );

  // Main sequencer. Reads are issued from read_addr and their data is
  // consumed two edges later, tracked by the rd_v0/rd_v1 shift pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= CONV_IDLE;
      busy            <= 1'b0;
      status          <= MATRIX_OP_STATUS_IDLE;
      bus.read_addr   <= '0;
      bus.write_request <= 1'b0;
      bus.matrix_id   <= '0;
      bus.actual_rows <= '0;
      bus.actual_cols <= '0;
      bus.matrix_name <= '0;
      bus.data_in     <= '0;
      bus.data_valid  <= 1'b0;
      k_id <= '0; i_id <= '0; d_id <= '0;
      s2 <= 1'b0; meta_phase <= 1'b0;
      kr <= '0; kc <= '0; ir <= '0; ic <= '0; or_n <= '0; oc_n <= '0;
      out_r <= '0; out_c <= '0; tkr <= '0; tkc <= '0;
      nk <= '0; iss_cnt <= '0; cap_cnt <= '0; tap_p0 <= '0; tap_p1 <= '0;
      rd_v0 <= 1'b0; rd_v1 <= 1'b0;
      for (int i = 0; i < KDEPTH; i++) kcache[i] <= '0;
    end else begin
      rd_v0  <= 1'b0;
      rd_v1  <= rd_v0;
      tap_p1 <= tap_p0;
      case (state)
        CONV_IDLE: if (start) begin
          k_id          <= kernel_src_id;
          i_id          <= image_src_id;
          d_id          <= dst_id;
          s2            <= stride2;
          bus.read_addr <= ADDR_WIDTH'(kernel_src_id) * ADDR_WIDTH'(BLOCK_SIZE);
          meta_phase    <= 1'b0;
          busy          <= 1'b1;
          status        <= MATRIX_OP_STATUS_BUSY;
          state         <= CONV_RD_META_K;
        end
        // Image metadata read overlaps the kernel metadata latency.
        CONV_RD_META_K: if (!meta_phase) begin
          bus.read_addr <= i_base;
          meta_phase    <= 1'b1;
        end else begin
          kr    <= bus.data_out[31:24];
          kc    <= bus.data_out[23:16];
          state <= CONV_RD_META_I;
        end
        CONV_RD_META_I: begin
          ir    <= bus.data_out[31:24];
          ic    <= bus.data_out[23:16];
          state <= CONV_CHECK;
        end
        CONV_CHECK: if (dim_bad) begin
          state <= CONV_ERROR;
        end else begin
          or_n          <= ((ir - kr) >> s2) + 8'd1;
          oc_n          <= ((ic - kc) >> s2) + 8'd1;
          nk            <= CW'(kr) * CW'(kc);
          bus.read_addr <= k_base + META;
          rd_v0         <= 1'b1;
          iss_cnt       <= CW'(1);
          cap_cnt       <= '0;
          state         <= CONV_LOAD_K;
        end
        CONV_LOAD_K: begin
          if (iss_cnt != nk) begin
            bus.read_addr <= bus.read_addr + ADDR_WIDTH'(1);
            rd_v0         <= 1'b1;
            iss_cnt       <= iss_cnt + CW'(1);
          end
          if (rd_v1) begin
            kcache[cap_cnt] <= bus.data_out;
            cap_cnt         <= cap_cnt + CW'(1);
            if (cap_cnt == nk - CW'(1)) begin
              bus.write_request <= 1'b1;
              bus.matrix_id     <= d_id;
              bus.actual_rows   <= or_n;
              bus.actual_cols   <= oc_n;
              bus.matrix_name   <= CONV_MATRIX_NAME;
              state             <= CONV_REQ_WR;
            end
          end
        end
        CONV_REQ_WR: if (bus.write_ready) begin
          bus.write_request <= 1'b0;
          out_r <= '0; out_c <= '0; tkr <= '0; tkc <= '0;
          iss_cnt <= '0; cap_cnt <= '0;
          state <= CONV_COMPUTE;
        end
        // Issue one image read per cycle; the result is ready the cycle
        // after the last product has been accumulated.
        CONV_COMPUTE: begin
          if (iss_cnt != nk) begin
            bus.read_addr <= img_addr;
            rd_v0         <= 1'b1;
            tap_p0        <= iss_cnt;
            iss_cnt       <= iss_cnt + CW'(1);
            if (tkc == kc - 8'd1) begin
              tkc <= '0;
              tkr <= tkr + 8'd1;
            end else begin
              tkc <= tkc + 8'd1;
            end
          end
          if (rd_v1) cap_cnt <= cap_cnt + CW'(1);
          if (cap_cnt == nk) begin
            bus.data_in    <= mac_acc;
            bus.data_valid <= 1'b1;
            state          <= CONV_EMIT;
          end
        end
        CONV_EMIT: if (bus.writer_ready) begin
          bus.data_valid <= 1'b0;
          iss_cnt <= '0; cap_cnt <= '0; tkr <= '0; tkc <= '0;
          if (out_c == oc_n - 8'd1) begin
            out_c <= '0;
            if (out_r == or_n - 8'd1) begin
              state <= CONV_WAIT_DONE;
            end else begin
              out_r <= out_r + 8'd1;
              state <= CONV_COMPUTE;
            end
          end else begin
            out_c <= out_c + 8'd1;
            state <= CONV_COMPUTE;
          end
        end
        CONV_WAIT_DONE: if (bus.write_done) state <= CONV_DONE;
        // Final status is published together with busy falling.
        CONV_DONE: begin
          busy   <= 1'b0;
          status <= MATRIX_OP_STATUS_SUCCESS;
          state  <= CONV_IDLE;
        end
        CONV_ERROR: begin
          busy   <= 1'b0;
          status <= MATRIX_OP_STATUS_ERR_DIM;
          state  <= CONV_IDLE;
        end
        default: state <= CONV_IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_op_conv_gen.md
MATRIX_OP_CONV_GEN -- requirements
Module: matrix_op_conv_gen

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 1024, words per matrix slot in BRAM.
REQ-002 SHALL have parameter ADDR_WIDTH, default 14, BRAM address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, element width, signed two's complement.
REQ-004 SHALL have parameter MAX_K, default 5, max kernel rows/cols.
REQ-005 SHALL have parameter MAX_DIM, default 32, max image rows/cols.
REQ-006 SHALL have ports: clk in 1, single clock, all logic on posedge; rst in 1, asynchronous, active-high reset.
REQ-007 SHALL have ports: start in 1, one-cycle go pulse; kernel_src_id in 3, kernel slot; image_src_id in 3, image slot; dst_id in 3, result slot; stride2 in 1, 0 = stride 1, 1 = stride 2.
REQ-008 SHALL have ports: busy out 1; status out matrix_op_status_e.
REQ-009 SHALL have ports: read_addr out ADDR_WIDTH; data_out in DATA_WIDTH, valid 1 cycle after read_addr.
REQ-010 SHALL have writer ports: write_request out 1; write_ready in 1; matrix_id out 3; actual_rows out 8; actual_cols out 8; matrix_name out 8x8; data_in out DATA_WIDTH; data_valid out 1; writer_ready in 1; write_done in 1.

Function
REQ-011 SHALL treat slot s as base s*BLOCK_SIZE, with metadata word rows[31:24], cols[23:16], and row-major data starting at base+MATRIX_METADATA_WORDS.
REQ-012 SHALL sample all id inputs and stride2 on start in IDLE, and SHALL ignore start while busy.
REQ-013 SHALL implement states IDLE, RD_META_K, RD_META_I, CHECK, LOAD_K, REQ_WR, COMPUTE, EMIT, WAIT_DONE, DONE, ERROR.
REQ-014 SHALL enter ERROR, with no write_request, when KR or KC is 0, KR or KC exceeds MAX_K, IR or IC exceeds MAX_DIM, or KR>IR or KC>IC; status becomes MATRIX_OP_STATUS_ERR_DIM.
REQ-015 SHALL compute OR=(IR-KR)/S+1 and OC=(IC-KC)/S+1, with S in {1,2} and floor division.
REQ-016 SHALL cache the kernel in an internal register array during LOAD_K, one BRAM read issued per cycle.
REQ-017 SHALL in REQ_WR hold write_request=1 with matrix_id=dst_id, actual_rows=OR, actual_cols=OC, and matrix_name="CONV" followed by four 0x00, until write_ready; it then drops write_request.
REQ-018 SHALL compute out[r][c] = sum over kr,kc of K[kr][kc]*I[r*S+kr][c*S+kc]: cross-correlation, no kernel flip.
REQ-019 SHALL issue one image read per cycle in COMPUTE, pipelined against the 1-cycle BRAM latency.
REQ-020 SHALL take the low DATA_WIDTH bits of each product and wrap the accumulator modulo 2^DATA_WIDTH.
REQ-021 SHALL produce outputs in row-major order.
REQ-022 SHALL in EMIT assert data_valid with data_in held stable until a cycle with writer_ready=1, which transfers exactly one element; it then returns to COMPUTE, or to WAIT_DONE after OR*OC transfers.
REQ-023 SHALL in WAIT_DONE wait for write_done, then go to DONE, set status MATRIX_OP_STATUS_SUCCESS, and return to IDLE next cycle.
REQ-024 SHALL assert busy in every state except IDLE.
REQ-025 SHALL hold status MATRIX_OP_STATUS_BUSY while busy, and hold the final status until the next accepted start.
REQ-026 SHALL produce a 1x1 output when kernel dims equal image dims.
REQ-027 SHALL ignore a write_done arriving before WAIT_DONE.

Reset
REQ-028 SHALL on rst force state IDLE immediately, including mid-operation, and drive busy=0, status=MATRIX_OP_STATUS_IDLE, write_request=0, data_valid=0, read_addr=0, data_in=0, matrix_id=0, actual_rows=0, actual_cols=0, matrix_name all 0x00, and clear counters and the kernel cache.

Structure
REQ-029 SHALL add MATRIX_OP_STATUS_IDLE, _BUSY and _ERR_DIM to matrix_op_status_e in matrix_op_defs_pkg, and reuse MATRIX_METADATA_WORDS from that package.
REQ-030 SHALL isolate the multiply-accumulate in one sub-module, conv_mac_unit, with clear, enable and wrapped accumulator output.

Verification
REQ-031 SHALL cover: 3x3 kernel of ones, 4x4 image 1..16, stride 1 -> 2x2 output 54, 63, 90, 99, then status SUCCESS.
REQ-032 SHALL cover: same kernel, 5x5 image 1..25, stride2=1 -> 2x2 output 63, 81, 153, 171.
REQ-033 SHALL cover: 6x6 kernel with MAX_K=5 -> ERR_DIM, write_request never asserted, busy low within 10 cycles.
REQ-034 SHALL cover: writer_ready toggling every cycle during REQ-031 -> identical 4 values, data_in stable while data_valid=1 and writer_ready=0.
REQ-035 SHALL cover: 1x1 kernel [2], 1x1 image [0x7FFFFFFF] -> single output 0xFFFFFFFE, actual_rows=actual_cols=1.
REQ-036 SHALL cover: rst asserted mid-COMPUTE -> all outputs at reset values the same cycle, and a following start completes REQ-031 correctly.
